div_seq_ctrl: RTL and testbench

- Sequencing controller between the EX stage and the 32-bit radix-2 divider wrapper (signed/unsigned, 64-bit {remainder, quotient} result, ready pulse).
- Latches operands and holds divider enable for the whole operation, stalls the pipeline until the result exists, and holds the result while the pipeline is frozen.
- Cancels on flush and short-circuits divide-by-zero.
- Owns the watchdog for a divider that never reports ready.

---
 rtl/div_seq_ctrl.sv | 133 +++++++++++++
 tb/tb_div_seq_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq_ctrl.sv
// Sequencing controller between the EX stage and a multi-cycle radix-2 divider.
// Launches the divider with latched operands, stalls EX until the result
// exists, and holds the result while the pipeline is frozen. Divide-by-zero
// completes without touching the divider, and a watchdog aborts a divider
// that never reports ready.
module div_seq_ctrl #(
  parameter int unsigned TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_signed,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  input  logic        pipe_stall,
  output logic        stall_out,
  output logic        res_valid,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        timeout_err,
  output logic        div_ena,
  output logic        div_signed,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [63:0] div_res,
  input  logic        div_ready
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_t;

  state_t          state_q;
  logic [CntW-1:0] cnt_q;
  logic [31:0]     a_q;
  logic [31:0]     b_q;
  logic            sgn_q;

  // Operands go to the divider straight from the latches, so they stay
  // stable for the whole operation regardless of what EX does.
  assign div_a      = a_q;
  assign div_b      = b_q;
  assign div_signed = sgn_q;

  // Stall request: EX waits from the request cycle until the result exists.
  always_comb begin
    stall_out = 1'b0;
    case (state_q)
      StIdle:  stall_out = req_valid & ~flush;
      StBusy:  stall_out = 1'b1;
      default: stall_out = 1'b0;
    endcase
  end

  // Controller FSM with registered outputs; flush overrides every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sgn_q       <= 1'b0;
      res_valid   <= 1'b0;
      res_hi      <= '0;
      res_lo      <= '0;
      timeout_err <= 1'b0;
      div_ena     <= 1'b0;
    end else if (flush) begin
      // A div_ready in this cycle is dropped; results are left as-is.
      state_q   <= StIdle;
      div_ena   <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            if (req_b != '0) begin
              a_q     <= req_a;
              b_q     <= req_b;
              sgn_q   <= req_signed;
              cnt_q   <= '0;
              div_ena <= 1'b1;
              state_q <= StBusy;
            end else begin
              // Divide-by-zero: remainder is the dividend, quotient all ones.
              res_hi    <= req_a;
              res_lo    <= '1;
              res_valid <= 1'b1;
              state_q   <= StDone;
            end
          end
        end
        StBusy: begin
          cnt_q <= cnt_q + CntW'(1);
          if (div_ready) begin
            res_hi    <= div_res[63:32];
            res_lo    <= div_res[31:0];
            res_valid <= 1'b1;
            div_ena   <= 1'b0;
            state_q   <= StDone;
          end else if (cnt_q == CntLast) begin
            timeout_err <= 1'b1;
            res_hi      <= '0;
            res_lo      <= '0;
            res_valid   <= 1'b1;
            div_ena     <= 1'b0;
            state_q     <= StDone;
          end
        end
        StDone: begin
          // Hold the result until EX is allowed to advance; passing through
          // IDLE guarantees div_ena is low for a cycle before a relaunch.
          if (!pipe_stall) begin
            res_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: begin
          div_ena   <= 1'b0;
          res_valid <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Bench for div_seq_ctrl: a behavioural divider with programmable latency
// (or none) feeds the DUT; directed cases plus random operations are checked
// against an arithmetic reference of the expected {remainder, quotient}.
module tb_div_seq_ctrl;

  localparam int unsigned TIMEOUT = 32;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_signed;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        flush;
  logic        pipe_stall;
  logic        stall_out;
  logic        res_valid;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        timeout_err;
  logic        div_ena;
  logic        div_signed;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [63:0] div_res;
  logic        div_ready;

  int checks = 0;
  int errors = 0;
  int dm_lat = 0;   // divider latency in enable cycles; 0 means never ready
  int dm_cnt = 0;

  div_seq_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_signed (req_signed),
    .req_a      (req_a),
    .req_b      (req_b),
    .flush      (flush),
    .pipe_stall (pipe_stall),
    .stall_out  (stall_out),
    .res_valid  (res_valid),
    .res_hi     (res_hi),
    .res_lo     (res_lo),
    .timeout_err(timeout_err),
    .div_ena    (div_ena),
    .div_signed (div_signed),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_res    (div_res),
    .div_ready  (div_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result: {remainder, quotient}, truncating division.
  function automatic logic [63:0] ref_div(input bit sg, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sg) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Divider model: counts enable cycles, restarts whenever enable drops.
  always @(posedge clk) begin
    if (!div_ena) dm_cnt <= 0;
    else          dm_cnt <= dm_cnt + 1;
  end

  always_comb begin
    div_ready = 1'b0;
    div_res   = ref_div(div_signed, div_a, div_b);
    if (div_ena && dm_lat != 0 && dm_cnt == dm_lat - 1) div_ready = 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete operation from the request cycle to the instruction leaving.
  // lat = 0 selects a divider that never answers (watchdog path).
  task automatic run_op(input bit sg, input logic [31:0] a, input logic [31:0] b, input int lat,
                        input int hold, input logic [31:0] e_hi, input logic [31:0] e_lo);
    int  n;
    int  exp_n;
    bit  done;
    dm_lat     = lat;
    req_valid  = 1'b1;
    req_signed = sg;
    req_a      = a;
    req_b      = b;
    pipe_stall = 1'b0;
    #1;
    chk("stall_req_cycle", stall_out, 1);
    n    = 0;
    done = 0;
    while (!done && n < 200) begin
      tick();
      n++;
      if (res_valid) begin
        done = 1;
      end else begin
        chk("busy_stall", stall_out, 1);
        chk("busy_ena", div_ena, 1);
        chk("busy_ops", {div_signed, div_a, div_b}, {sg, a, b});
      end
    end
    if (b == 32'd0)    exp_n = 1;
    else if (lat == 0) exp_n = TIMEOUT + 1;
    else               exp_n = lat + 1;
    chk("latency", n, exp_n);
    chk("res_hi", res_hi, e_hi);
    chk("res_lo", res_lo, e_lo);
    chk("done_ena", div_ena, 0);
    chk("done_stall", stall_out, 0);
    pipe_stall = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", res_valid, 1);
      chk("hold_res", {res_hi, res_lo}, {e_hi, e_lo});
      chk("hold_no_ena", div_ena, 0);
      chk("hold_stall", stall_out, 0);
      if (i == hold - 1) pipe_stall = 1'b0;
    end
    tick();
    chk("release_valid", res_valid, 0);
    chk("release_ena", div_ena, 0);
    req_valid = 1'b0;
    #1;
    chk("idle_stall", stall_out, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] e;
    bit          sg;
    logic [31:0] a;
    logic [31:0] b;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_signed = 1'b0;
    req_a      = '0;
    req_b      = '0;
    flush      = 1'b0;
    pipe_stall = 1'b0;
    #1;
    chk("rst_state", {stall_out, res_valid, timeout_err, div_ena, div_signed},
        5'b0);
    chk("rst_res", {res_hi, res_lo}, 64'd0);
    chk("rst_ops", {div_a, div_b}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // DIVU 100/7, 17-cycle divider.
    run_op(1'b0, 32'd100, 32'd7, 17, 0, 32'd2, 32'd14);
    // DIV -7/2.
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 6, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    // DIVU 5/0 short-circuit.
    run_op(1'b0, 32'd5, 32'd0, 9, 0, 32'd5, 32'hFFFF_FFFF);
    // Result held through a 4-cycle downstream stall.
    run_op(1'b0, 32'd1000, 32'd33, 4, 4, 32'd10, 32'd30);

    // Flush in BUSY cycle 8, coinciding with div_ready; result is discarded.
    dm_lat     = 8;
    req_valid  = 1'b1;
    req_signed = 1'b0;
    req_a      = 32'd100;
    req_b      = 32'd9;
    for (int i = 0; i < 8; i++) tick();
    chk("flush_ready_seen", div_ready, 1);
    flush     = 1'b1;
    req_valid = 1'b0;
    tick();
    flush = 1'b0;
    chk("flush_valid", res_valid, 0);
    chk("flush_ena", div_ena, 0);
    run_op(1'b0, 32'd9, 32'd3, 5, 0, 32'd0, 32'd3);

    // Divider never answers: watchdog fires after TIMEOUT busy cycles.
    chk("err_before", timeout_err, 0);
    run_op(1'b0, 32'd64, 32'd4, 0, 0, 32'd0, 32'd0);
    chk("err_set", timeout_err, 1);
    run_op(1'b0, 32'd77, 32'd10, 3, 1, 32'd7, 32'd7);
    chk("err_sticky", timeout_err, 1);

    // Random operations.
    for (int k = 0; k < 12; k++) begin
      sg = 1'($urandom_range(1, 0));
      a  = $urandom;
      b  = ($urandom_range(3, 0) == 0) ? 32'd0 : $urandom;
      if (sg && b == 32'hFFFF_FFFF) b = 32'd3;
      if ($urandom_range(1, 0) == 1) b = b >> $urandom_range(28, 0);
      e = ref_div(sg, a, b);
      run_op(sg, a, b, $urandom_range(20, 1), $urandom_range(2, 0), e[63:32], e[31:0]);
      chk("rnd_no_err_change", timeout_err, 1);
    end

    // Asynchronous reset in the middle of BUSY.
    dm_lat     = 0;
    req_valid  = 1'b1;
    req_signed = 1'b1;
    req_a      = 32'd50;
    req_b      = 32'd5;
    for (int i = 0; i < 5; i++) tick();
    chk("pre_rst_ena", div_ena, 1);
    #2;
    rst       = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("arst_ctl", {stall_out, res_valid, timeout_err, div_ena, div_signed}, 5'b0);
    chk("arst_res", {res_hi, res_lo}, 64'd0);
    chk("arst_ops", {div_a, div_b}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    run_op(1'b1, 32'hFFFF_FF9C, 32'd7, 10, 0, 32'hFFFF_FFFE, 32'hFFFF_FFF2);
    chk("final_err_clear", timeout_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
